modulator_signal_mux: RTL and testbench
=======================================

Name: modulator_signal_mux

Overview:
- Parametrised, registered selector for the signal generator/modulator datapath. Picks one of N_WAVE base waveforms and one of N_MOD modulation variants of that waveform, and drives the chosen unmodulated and modulated samples to the DAC/Avalon side.
- Selection changes requested by the Nios register interface are held pending. They are applied only at a carrier-cycle boundary, so the output never jumps mid-period. A sample-count timeout forces the switch if no boundary arrives.

Parameters:
W, 12, sample width in bits
N_WAVE, 4, number of base waveforms (0 sin, 1 cos, 2 square, 3 saw)
N_MOD, 3, number of modulation modes (0 none, 1 BPSK, 2 ASK)
SWITCH_TIMEOUT, 4096, sample_en pulses allowed while pending before a forced switch (>=2)
WS, $clog2(N_WAVE), waveform selector width (derived)
MS, $clog2(N_MOD), modulation selector width (derived)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_en  in  1  one-cycle strobe, new input samples valid this cycle
cycle_start  in  1  carrier period boundary; meaningful only with sample_en
data_in  in  N_MOD*N_WAVE*W  flattened samples; slot (m*N_WAVE+w) holds mode m of wave w; mode 0 is the raw wave
sel_load  in  1  one-cycle strobe, request new selection
sig_sel  in  WS  requested waveform index
mod_sel  in  MS  requested modulation index
selected_signal  out  W  registered raw sample of the active wave (slot active_sig)
selected_modulation  out  W  registered sample of the active wave/mode (slot active_mod*N_WAVE+active_sig)
out_valid  out  1  pulses one cycle after each sample_en
busy  out  1  high while a request is pending
switched  out  1  one-cycle pulse when a selection is applied
forced  out  1  one-cycle pulse when a switch was caused by timeout (coincident with switched)
sel_err  out  1  one-cycle pulse on rejected request
active_sig  out  WS  currently applied waveform index
active_mod  out  MS  currently applied modulation index

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0. FSM goes to IDLE. Pending registers and timeout counter go to 0.
  - A reset mid-pending discards the request. Active selection returns to 0/0.
- Request validation: on sel_load, the request is valid iff sig_sel<N_WAVE and mod_sel<N_MOD.
  - Invalid: sel_err=1 the next cycle. State, pending and active are unchanged.
  - Valid: pend_sig/pend_mod <= inputs, timeout counter <= 0, FSM -> PENDING.
  - Last request wins: a valid load while PENDING overwrites the pending values and restarts the counter.
- FSM states:
  - IDLE: busy=0. A valid sel_load moves to PENDING.
  - PENDING: busy=1. A switch event occurs on sample_en && (cycle_start || cnt==SWITCH_TIMEOUT-1).
    - On a switch event: active <= pending; switched=1 the next cycle; forced=1 the next cycle if cycle_start=0; return to IDLE.
    - On sample_en without a switch event: cnt increments.
- Sample path: on sample_en, selected_signal/selected_modulation <= data_in slots indexed by the effective selection, and out_valid=1 the next cycle. Latency is 1 clock.
  - Effective selection = pending values if a switch event occurs this cycle, otherwise active values.
  - The boundary sample is therefore the first sample produced with the new selection.
  - Outputs hold between sample_en pulses.
- Simultaneous sel_load and switch event: the switch applies the OLD pending values. The new valid request becomes the next pending (FSM stays PENDING, counter resets to 0). An invalid one raises sel_err and the FSM goes to IDLE.
- sel_load in IDLE together with sample_en && cycle_start: the request is captured only. The switch waits for the next boundary; no same-cycle application.
- cycle_start without sample_en is ignored.
- Width rule: pure selection; no arithmetic on samples. Samples are passed bit-exact.

Test Plan:
- Reset, then sample_en with slot0=0x123 -> one cycle later selected_signal=selected_modulation=0x123, out_valid=1; active_sig=active_mod=0.
- Mid-period sel_load sig=2, mod=1 -> busy=1, and outputs keep slot 0 across 5 sample_en without cycle_start. On sample_en+cycle_start with slot6=0xABC and slot2=0x7FF, one cycle later selected_modulation=0xABC, selected_signal=0x7FF, switched=1, forced=0, busy=0.
- Pending with no cycle_start for 4096 sample_en pulses -> switch on the 4096th pulse, switched=1, forced=1. A pulse count of 4095 leaves busy=1.
- sel_load with sig=1, mod=3 (N_MOD=3) -> sel_err pulse, busy and active unchanged. Then two valid loads (1,1) then (3,2) before the boundary -> active becomes 3/2.
- sel_load (1,0) in the same cycle as a boundary switch of pending (2,2) -> active=2/2, busy stays 1. The next boundary gives active=1/0.
- Reset asserted while PENDING -> busy=0 and active=0/0. The next boundary produces no switched pulse.

Source files
------------

// File: rtl/modulator_signal_mux_if.sv
// Bundle of the selection-request, sample-input and selected-output signals.
interface modulator_signal_mux_if #(
  parameter int unsigned W      = 12,
  parameter int unsigned N_WAVE = 4,
  parameter int unsigned N_MOD  = 3
);
  localparam int unsigned WS = (N_WAVE > 1) ? $clog2(N_WAVE) : 1;
  localparam int unsigned MS = (N_MOD > 1) ? $clog2(N_MOD) : 1;
  localparam int unsigned DW = N_MOD * N_WAVE * W;

  logic          sample_en;
  logic          cycle_start;
  logic [DW-1:0] data_in;
  logic          sel_load;
  logic [WS-1:0] sig_sel;
  logic [MS-1:0] mod_sel;

  logic [W-1:0]  selected_signal;
  logic [W-1:0]  selected_modulation;
  logic          out_valid;
  logic          busy;
  logic          switched;
  logic          forced;
  logic          sel_err;
  logic [WS-1:0] active_sig;
  logic [MS-1:0] active_mod;

  modport master (
    output sample_en, cycle_start, data_in, sel_load, sig_sel, mod_sel,
    input  selected_signal, selected_modulation, out_valid, busy, switched,
           forced, sel_err, active_sig, active_mod
  );

  modport slave (
    input  sample_en, cycle_start, data_in, sel_load, sig_sel, mod_sel,
    output selected_signal, selected_modulation, out_valid, busy, switched,
           forced, sel_err, active_sig, active_mod
  );
endinterface

// File: rtl/modulator_signal_mux.sv
// Registered waveform/modulation selector; selection changes are deferred
// to a carrier-period boundary, with a sample-count timeout as a fallback.
module modulator_signal_mux #(
  parameter int unsigned W              = 12,
  parameter int unsigned N_WAVE         = 4,
  parameter int unsigned N_MOD          = 3,
  parameter int unsigned SWITCH_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  modulator_signal_mux_if.slave  bus
);
  localparam int unsigned WS = (N_WAVE > 1) ? $clog2(N_WAVE) : 1;
  localparam int unsigned MS = (N_MOD > 1) ? $clog2(N_MOD) : 1;
  localparam int unsigned CW = $clog2(SWITCH_TIMEOUT);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e        state_q, state_d;
  logic [WS-1:0] pend_sig_q, pend_sig_d;
  logic [MS-1:0] pend_mod_q, pend_mod_d;
  logic [WS-1:0] act_sig_q, act_sig_d;
  logic [MS-1:0] act_mod_q, act_mod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sel_sig_q, sel_sig_d;
  logic [W-1:0]  sel_mod_q, sel_mod_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          switched_q, switched_d;
  logic          forced_q, forced_d;
  logic          sel_err_q, sel_err_d;

  logic          req_ok;
  logic          switch_ev;
  logic [WS-1:0] eff_sig;
  logic [MS-1:0] eff_mod;

  // Unflatten the sample bus into [mode][wave] slots.
  logic [W-1:0] slots [N_MOD][N_WAVE];
  for (genvar m = 0; m < N_MOD; m++) begin : g_mod
    for (genvar w = 0; w < N_WAVE; w++) begin : g_wave
      assign slots[m][w] = bus.data_in[(m*N_WAVE+w)*W +: W];
    end
  end

  // Request validation, switch detection and next-state computation.
  always_comb begin
    state_d     = state_q;
    pend_sig_d  = pend_sig_q;
    pend_mod_d  = pend_mod_q;
    act_sig_d   = act_sig_q;
    act_mod_d   = act_mod_q;
    cnt_d       = cnt_q;
    sel_sig_d   = sel_sig_q;
    sel_mod_d   = sel_mod_q;
    out_valid_d = bus.sample_en;
    switched_d  = 1'b0;
    forced_d    = 1'b0;

    req_ok    = (32'(bus.sig_sel) < N_WAVE) && (32'(bus.mod_sel) < N_MOD);
    sel_err_d = bus.sel_load && !req_ok;
    switch_ev = (state_q == PENDING) && bus.sample_en &&
                (bus.cycle_start || (cnt_q == CW'(SWITCH_TIMEOUT - 1)));

    // The boundary sample already uses the new selection.
    eff_sig = switch_ev ? pend_sig_q : act_sig_q;
    eff_mod = switch_ev ? pend_mod_q : act_mod_q;

    if (switch_ev) begin
      act_sig_d  = pend_sig_q;
      act_mod_d  = pend_mod_q;
      switched_d = 1'b1;
      forced_d   = !bus.cycle_start;
      state_d    = IDLE;
    end else if ((state_q == PENDING) && bus.sample_en) begin
      cnt_d = cnt_q + CW'(1);
    end

    // A valid load always becomes the new pending request (last one wins).
    if (bus.sel_load && req_ok) begin
      pend_sig_d = bus.sig_sel;
      pend_mod_d = bus.mod_sel;
      cnt_d      = '0;
      state_d    = PENDING;
    end

    if (bus.sample_en) begin
      sel_sig_d = slots[0][eff_sig];
      sel_mod_d = slots[eff_mod][eff_sig];
    end

    busy_d = (state_d == PENDING);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_sig_q  <= '0;
      pend_mod_q  <= '0;
      act_sig_q   <= '0;
      act_mod_q   <= '0;
      cnt_q       <= '0;
      sel_sig_q   <= '0;
      sel_mod_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      switched_q  <= 1'b0;
      forced_q    <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_sig_q  <= pend_sig_d;
      pend_mod_q  <= pend_mod_d;
      act_sig_q   <= act_sig_d;
      act_mod_q   <= act_mod_d;
      cnt_q       <= cnt_d;
      sel_sig_q   <= sel_sig_d;
      sel_mod_q   <= sel_mod_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      switched_q  <= switched_d;
      forced_q    <= forced_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.selected_signal     = sel_sig_q;
  assign bus.selected_modulation = sel_mod_q;
  assign bus.out_valid           = out_valid_q;
  assign bus.busy                = busy_q;
  assign bus.switched            = switched_q;
  assign bus.forced              = forced_q;
  assign bus.sel_err             = sel_err_q;
  assign bus.active_sig          = act_sig_q;
  assign bus.active_mod          = act_mod_q;
endmodule

// File: tb/tb_modulator_signal_mux.sv
// Directed bench for modulator_signal_mux with hand-computed expectations.
module tb_modulator_signal_mux;
  localparam int unsigned W      = 12;
  localparam int unsigned N_WAVE = 4;
  localparam int unsigned N_MOD  = 3;
  localparam int unsigned TO     = 4096;
  localparam int unsigned NS     = N_MOD * N_WAVE;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] slot_v [NS];

  int n_tests = 0;
  int n_fail  = 0;

  modulator_signal_mux_if #(.W(W), .N_WAVE(N_WAVE), .N_MOD(N_MOD)) bus ();

  modulator_signal_mux #(
    .W(W), .N_WAVE(N_WAVE), .N_MOD(N_MOD), .SWITCH_TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  for (genvar s = 0; s < NS; s++) begin : g_slot
    assign bus.data_in[s*W +: W] = slot_v[s];
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic cs);
    bus.sample_en   = 1'b1;
    bus.cycle_start = cs;
    step();
    bus.sample_en   = 1'b0;
    bus.cycle_start = 1'b0;
  endtask

  task automatic load(input int s, input int m);
    bus.sel_load = 1'b1;
    bus.sig_sel  = 2'(s);
    bus.mod_sel  = 2'(m);
    step();
    bus.sel_load = 1'b0;
  endtask

  task automatic check_active(input string tag, input int s, input int m);
    check({tag, ".sig"}, 32'(bus.active_sig), 32'(s));
    check({tag, ".mod"}, 32'(bus.active_mod), 32'(m));
  endtask

  initial begin
    bus.sample_en   = 1'b0;
    bus.cycle_start = 1'b0;
    bus.sel_load    = 1'b0;
    bus.sig_sel     = '0;
    bus.mod_sel     = '0;
    for (int i = 0; i < int'(NS); i++) slot_v[i] = 12'(16 * i + 1);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst.sig_out", 32'(bus.selected_signal), 0);
    check("rst.mod_out", 32'(bus.selected_modulation), 0);
    check("rst.valid", 32'(bus.out_valid), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check_active("rst.act", 0, 0);

    // First sample through slot 0, one-cycle latency
    slot_v[0] = 12'h123;
    sample(1'b0);
    check("t1.sig_out", 32'(bus.selected_signal), 32'h123);
    check("t1.mod_out", 32'(bus.selected_modulation), 32'h123);
    check("t1.valid", 32'(bus.out_valid), 1);
    check_active("t1.act", 0, 0);
    slot_v[0] = 12'h456;
    step();
    check("t1.valid_drop", 32'(bus.out_valid), 0);
    check("t1.hold", 32'(bus.selected_signal), 32'h123);

    // Mid-period request stays pending across samples without boundary
    load(2, 1);
    check("t2.busy", 32'(bus.busy), 1);
    check("t2.no_err", 32'(bus.sel_err), 0);
    for (int i = 0; i < 5; i++) begin
      slot_v[0] = 12'(12'h100 + i);
      sample(1'b0);
      check("t2.keep_slot0", 32'(bus.selected_modulation), 32'(12'h100 + i));
    end
    bus.cycle_start = 1'b1;
    step();
    bus.cycle_start = 1'b0;
    check("t2.cs_no_en", 32'(bus.busy), 1);
    slot_v[6] = 12'hABC;
    slot_v[2] = 12'h7FF;
    sample(1'b1);
    check("t2.mod_out", 32'(bus.selected_modulation), 32'hABC);
    check("t2.sig_out", 32'(bus.selected_signal), 32'h7FF);
    check("t2.switched", 32'(bus.switched), 1);
    check("t2.forced", 32'(bus.forced), 0);
    check("t2.busy", 32'(bus.busy), 0);
    check_active("t2.act", 2, 1);
    step();
    check("t2.sw_pulse", 32'(bus.switched), 0);

    // Timeout: 4095 pulses keep pending, 4096th forces the switch
    load(1, 2);
    for (int i = 0; i < int'(TO) - 1; i++) sample(1'b0);
    check("t3.busy_4095", 32'(bus.busy), 1);
    check("t3.no_sw_4095", 32'(bus.switched), 0);
    check_active("t3.act_4095", 2, 1);
    slot_v[9] = 12'h5A5;
    slot_v[1] = 12'h0F0;
    sample(1'b0);
    check("t3.switched", 32'(bus.switched), 1);
    check("t3.forced", 32'(bus.forced), 1);
    check("t3.busy", 32'(bus.busy), 0);
    check("t3.mod_out", 32'(bus.selected_modulation), 32'h5A5);
    check("t3.sig_out", 32'(bus.selected_signal), 32'h0F0);
    check_active("t3.act", 1, 2);
    step();
    check("t3.forced_pulse", 32'(bus.forced), 0);

    // Invalid request rejected; then last valid request wins
    load(1, 3);
    check("t4.sel_err", 32'(bus.sel_err), 1);
    check("t4.busy", 32'(bus.busy), 0);
    check_active("t4.act", 1, 2);
    step();
    check("t4.err_pulse", 32'(bus.sel_err), 0);
    load(1, 1);
    load(3, 2);
    check("t4.busy2", 32'(bus.busy), 1);
    slot_v[11] = 12'h321;
    slot_v[3]  = 12'h654;
    sample(1'b1);
    check_active("t4.act2", 3, 2);
    check("t4.mod_out", 32'(bus.selected_modulation), 32'h321);
    check("t4.sig_out", 32'(bus.selected_signal), 32'h654);

    // Load coincident with a boundary switch becomes the next pending
    load(2, 2);
    slot_v[10] = 12'h2A2;
    bus.sel_load = 1'b1;
    bus.sig_sel  = 2'd1;
    bus.mod_sel  = 2'd0;
    sample(1'b1);
    bus.sel_load = 1'b0;
    check_active("t5.act", 2, 2);
    check("t5.busy", 32'(bus.busy), 1);
    check("t5.switched", 32'(bus.switched), 1);
    check("t5.mod_out", 32'(bus.selected_modulation), 32'h2A2);
    slot_v[1] = 12'h0F1;
    sample(1'b1);
    check_active("t5.act2", 1, 0);
    check("t5.busy2", 32'(bus.busy), 0);
    check("t5.mod_out2", 32'(bus.selected_modulation), 32'h0F1);

    // Load in IDLE together with a boundary is captured only
    bus.sel_load = 1'b1;
    bus.sig_sel  = 2'd0;
    bus.mod_sel  = 2'd2;
    sample(1'b1);
    bus.sel_load = 1'b0;
    check("t6.no_sw", 32'(bus.switched), 0);
    check("t6.busy", 32'(bus.busy), 1);
    check_active("t6.act", 1, 0);

    // Reset while pending discards the request
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7.busy", 32'(bus.busy), 0);
    check_active("t7.act", 0, 0);
    check("t7.sig_out", 32'(bus.selected_signal), 0);
    slot_v[0] = 12'h777;
    sample(1'b1);
    check("t7.no_sw", 32'(bus.switched), 0);
    check("t7.busy2", 32'(bus.busy), 0);
    check_active("t7.act2", 0, 0);
    check("t7.sig_out2", 32'(bus.selected_signal), 32'h777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
